// File: rtl/balance_ctrl_seq.sv
// Sequencer for the balance-loop duty datapath: builds the P/I/D operands from
// each pitch sample, then registers the duty result with a one-cycle valid strobe.
module balance_ctrl_seq #(
  parameter int D_DLY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic [15:0]         ptch,
  input  logic                pwr_up,
  input  logic                rider_off,
  output logic signed [9:0]   ptch_err_sat,
  output logic signed [9:0]   ptch_err_I,
  output logic signed [6:0]   ptch_D_diff_sat,
  input  logic [11:0]         mtr_duty_in,
  input  logic                rev_in,
  output logic [11:0]         mtr_duty,
  output logic                rev,
  output logic                duty_vld,
  output logic                ovr
);

  typedef enum logic [1:0] {IDLE, CALC, UPDT, CAPT} state_t;

  state_t             state;
  logic signed [9:0]  err_reg;
  logic signed [17:0] integ;
  logic signed [9:0]  hist [D_DLY];
  logic signed [6:0]  d_reg;

  logic signed [15:0] ptch_s;
  logic signed [9:0]  err_sat;
  logic signed [10:0] diff;
  logic signed [6:0]  diff_sat;
  logic signed [17:0] integ_sum;
  logic               integ_ovf;

  assign ptch_s = $signed(ptch);

  always_comb begin
    err_sat = ptch_s[9:0];
    if (ptch_s > 16'sd511)
      err_sat = 10'sd511;
    else if (ptch_s < -16'sd512)
      err_sat = -10'sd512;
  end

  // Derivative compares against the sample D_DLY positions back in the queue.
  assign diff = {err_reg[9], err_reg} - {hist[D_DLY-1][9], hist[D_DLY-1]};

  always_comb begin
    diff_sat = diff[6:0];
    if (diff > 11'sd63)
      diff_sat = 7'sd63;
    else if (diff < -11'sd64)
      diff_sat = -7'sd64;
  end

  // On overflow the integrator simply holds rather than clamping to the rail.
  assign integ_sum = integ + {{8{err_reg[9]}}, err_reg};
  assign integ_ovf = (integ[17] == err_reg[9]) && (integ_sum[17] != integ[17]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_reg  <= '0;
      integ    <= '0;
      d_reg    <= '0;
      mtr_duty <= '0;
      rev      <= 1'b0;
      duty_vld <= 1'b0;
      ovr      <= 1'b0;
      for (int i = 0; i < D_DLY; i++) hist[i] <= '0;
    end else if (!pwr_up) begin
      state    <= IDLE;
      err_reg  <= '0;
      integ    <= '0;
      d_reg    <= '0;
      mtr_duty <= '0;
      rev      <= 1'b0;
      duty_vld <= 1'b0;
      for (int i = 0; i < D_DLY; i++) hist[i] <= '0;
    end else begin
      duty_vld <= 1'b0;

      if (rider_off)
        integ <= '0;
      else if (state == CALC && !integ_ovf)
        integ <= integ_sum;

      if (vld && state != IDLE)
        ovr <= 1'b1;

      case (state)
        IDLE: begin
          if (vld) begin
            state   <= CALC;
            err_reg <= err_sat;
          end
        end
        CALC: begin
          state   <= UPDT;
          d_reg   <= diff_sat;
          hist[0] <= err_reg;
          for (int i = 1; i < D_DLY; i++) hist[i] <= hist[i-1];
        end
        UPDT: begin
          state    <= CAPT;
          mtr_duty <= mtr_duty_in;
          rev      <= rev_in;
          duty_vld <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ptch_err_sat    = err_reg;
  assign ptch_err_I      = integ[17:8];
  assign ptch_D_diff_sat = d_reg;

endmodule

// File: tb/tb_balance_ctrl_seq.sv
// Directed/random bench for balance_ctrl_seq against an arithmetic model of the
// P/I/D operand rules and the duty capture timing.
module tb_balance_ctrl_seq;

  localparam int D_DLY = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic [15:0]        ptch;
  logic               pwr_up;
  logic               rider_off;
  logic signed [9:0]  ptch_err_sat;
  logic signed [9:0]  ptch_err_I;
  logic signed [6:0]  ptch_D_diff_sat;
  logic [11:0]        mtr_duty_in;
  logic               rev_in;
  logic [11:0]        mtr_duty;
  logic               rev;
  logic               duty_vld;
  logic               ovr;

  balance_ctrl_seq #(.D_DLY(D_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .pwr_up(pwr_up),
    .rider_off(rider_off), .ptch_err_sat(ptch_err_sat), .ptch_err_I(ptch_err_I),
    .ptch_D_diff_sat(ptch_D_diff_sat), .mtr_duty_in(mtr_duty_in), .rev_in(rev_in),
    .mtr_duty(mtr_duty), .rev(rev), .duty_vld(duty_vld), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference state, expressed as plain integers.
  int   m_err, m_integ, m_d;
  int   m_hist [D_DLY];
  int   m_duty, m_rev, m_ovr;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit keep_ovr);
    m_err = 0; m_integ = 0; m_d = 0; m_duty = 0; m_rev = 0;
    for (int i = 0; i < D_DLY; i++) m_hist[i] = 0;
    if (!keep_ovr) m_ovr = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_err"}, ptch_err_sat, 0);
    chk({tag, "_I"}, ptch_err_I, 0);
    chk({tag, "_D"}, ptch_D_diff_sat, 0);
    chk({tag, "_duty"}, {20'b0, mtr_duty}, 0);
    chk({tag, "_rev"}, {31'b0, rev}, 0);
    chk({tag, "_dvld"}, {31'b0, duty_vld}, 0);
  endtask

  // One full transaction; inputs change 1 time unit after each rising edge.
  task automatic sample(input logic [15:0] p, input logic [11:0] md, input logic r,
                        input bit ovrun, input bit rhold);
    int t;
    ptch = p; vld = 1'b1; mtr_duty_in = md; rev_in = r; rider_off = rhold;
    @(posedge clk); #1;
    vld = ovrun;
    m_err = clamp(int'($signed(p)), -512, 511);
    chk("err_calc", ptch_err_sat, m_err);
    chk("dvld_calc", {31'b0, duty_vld}, 0);

    @(posedge clk); #1;
    vld = 1'b0;
    if (ovrun) m_ovr = 1;
    if (rhold) m_integ = 0;
    else begin
      t = m_integ + m_err;
      if (t <= 131071 && t >= -131072) m_integ = t;
    end
    m_d = clamp(m_err - m_hist[D_DLY-1], -64, 63);
    for (int i = D_DLY - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_err;
    chk("err_updt", ptch_err_sat, m_err);
    chk("I_updt", ptch_err_I, m_integ >>> 8);
    chk("D_updt", ptch_D_diff_sat, m_d);
    chk("dvld_updt", {31'b0, duty_vld}, 0);
    chk("ovr_updt", {31'b0, ovr}, m_ovr);

    @(posedge clk); #1;
    rider_off = 1'b0;
    m_duty = int'(md); m_rev = int'(r);
    chk("dvld_capt", {31'b0, duty_vld}, 1);
    chk("duty_capt", {20'b0, mtr_duty}, m_duty);
    chk("rev_capt", {31'b0, rev}, m_rev);
    chk("D_capt", ptch_D_diff_sat, m_d);

    @(posedge clk); #1;
    chk("dvld_idle", {31'b0, duty_vld}, 0);
    chk("I_idle", ptch_err_I, m_integ >>> 8);
    txn++;
    $display("txn %0d ptch=%0d err=%0d I=%0d D=%0d duty=%h rev=%0d ovr=%0d",
             txn, $signed(p), ptch_err_sat, ptch_err_I, ptch_D_diff_sat, mtr_duty, rev, ovr);
  endtask

  task automatic rider_pulse();
    rider_off = 1'b1;
    @(posedge clk); #1;
    rider_off = 1'b0;
    m_integ = 0;
    chk("I_rider", ptch_err_I, 0);
  endtask

  initial begin
    logic [15:0] rp;
    rst_n = 1'b0; vld = 1'b0; ptch = '0; pwr_up = 1'b0; rider_off = 1'b0;
    mtr_duty_in = '0; rev_in = 1'b0;
    model_clear(1'b0);
    #1;
    chk_all_zero("rst");
    chk("rst_ovr", {31'b0, ovr}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    pwr_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("post_rst");

    // Single sample from a cleared state.
    sample(16'h0100, 12'h123, 1'b0, 1'b0, 1'b0);

    // Saturation limits and derivative against the sample two back.
    sample(16'h7FFF, 12'h456, 1'b1, 1'b0, 1'b0);
    sample(16'h8000, 12'h789, 1'b0, 1'b0, 1'b0);
    sample(16'h0000, 12'hABC, 1'b1, 1'b0, 1'b0);

    // Random samples, mixing rail-hitting and in-range pitch values.
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) rp = 16'($urandom);
      else            rp = 16'(int'($urandom_range(0, 1200)) - 600);
      sample(rp, 12'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // rider_off held through a sample wins over the accumulation.
    sample(16'h0123, 12'h0F0, 1'b0, 1'b0, 1'b1);

    // Positive and negative integrator clamps.
    rider_pulse();
    for (int k = 0; k < 257; k++) sample(16'h01FF, 12'h111, 1'b0, 1'b0, 1'b0);
    chk("I_pos_clamp", ptch_err_I, 511);
    rider_pulse();
    for (int k = 0; k < 257; k++) sample(16'h8000, 12'h222, 1'b1, 1'b0, 1'b0);
    chk("I_neg_clamp", ptch_err_I, -512);
    rider_pulse();

    // Power drop during UPDT drops the sample and clears state.
    sample(16'd40, 12'h333, 1'b0, 1'b0, 1'b0);
    sample(16'd40, 12'h344, 1'b1, 1'b0, 1'b0);
    ptch = 16'd77; vld = 1'b1; mtr_duty_in = 12'h555;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk); #1;
    pwr_up = 1'b0;
    @(posedge clk); #1;
    model_clear(1'b1);
    chk_all_zero("pdrop");
    pwr_up = 1'b1;
    @(posedge clk); #1;
    chk("pdrop_dvld2", {31'b0, duty_vld}, 0);
    sample(16'd20, 12'h666, 1'b1, 1'b0, 1'b0);
    chk("pdrop_D", ptch_D_diff_sat, 20);

    // Overrun: second vld during CALC is ignored and ovr sticks.
    sample(16'd100, 12'h777, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("ovr_no_extra", {31'b0, duty_vld}, 0);
    sample(16'hFF00, 12'h888, 1'b1, 1'b0, 1'b0);
    sample(16'd5, 12'h999, 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", {31'b0, ovr}, 1);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    sample(16'd200, 12'hDEF, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_clear(1'b0);
    chk_all_zero("async_rst");
    chk("async_rst_ovr", {31'b0, ovr}, 0);
    @(posedge clk); #4 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
